// File: rtl/vga_console_writer.sv
// Terminal-style writer for the VGA console text buffer: keeps a cursor, interprets
// CR/LF/BS, wraps at end of line, scrolls at the bottom and shares the write port with the host.
module vga_console_writer #(
    parameter int         NUM_ROWS   = 3,
    parameter int         NUM_COLS   = 10,
    parameter int         ADDR_W     = 5,
    parameter logic [6:0] BLANK_CHAR = 7'h20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              char_valid,
    input  logic [6:0]        char_data,
    output logic              char_ready,
    input  logic              clear,
    input  logic              host_wr_en,
    input  logic [ADDR_W-1:0] host_wr_addr,
    input  logic [6:0]        host_wr_data,
    output logic              buf_wr_en,
    output logic [ADDR_W-1:0] buf_wr_addr,
    output logic [6:0]        buf_wr_data,
    output logic [ADDR_W-1:0] buf_rd_addr,
    input  logic [6:0]        buf_rd_data,
    output logic [1:0]        cursor_row,
    output logic [3:0]        cursor_col,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_SCROLL_COPY = 2'd1,
        ST_SCROLL_FILL = 2'd2,
        ST_CLEAR       = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] COLS_A     = ADDR_W'(NUM_COLS);
    localparam logic [ADDR_W-1:0] COPY_LAST  = ADDR_W'((NUM_ROWS - 1) * NUM_COLS - 1);
    localparam logic [ADDR_W-1:0] FILL_FIRST = ADDR_W'((NUM_ROWS - 1) * NUM_COLS);
    localparam logic [ADDR_W-1:0] LAST_CELL  = ADDR_W'(NUM_ROWS * NUM_COLS - 1);
    localparam logic [3:0]        LAST_COL   = 4'(NUM_COLS - 1);
    localparam logic [1:0]        LAST_ROW   = 2'(NUM_ROWS - 1);

    localparam logic [6:0] CH_BS = 7'h08;
    localparam logic [6:0] CH_LF = 7'h0A;
    localparam logic [6:0] CH_CR = 7'h0D;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   idx, idx_nxt;
    logic [1:0]          row_nxt;
    logic [3:0]          col_nxt;
    logic                eng_wr_en;
    logic [ADDR_W-1:0]   eng_wr_addr;
    logic [6:0]          eng_wr_data;
    logic                line_feed;
    logic                accept;
    logic                printable;
    logic                advance;
    logic [ADDR_W-1:0]   cur_addr;

    // Stream handshake: a character moves on a cycle where char_valid and char_ready
    // are both high; char_ready is purely combinational and there is no skid buffer.
    assign char_ready = rst_n & (state == ST_IDLE) & ~host_wr_en & ~clear;
    assign accept     = char_valid & char_ready;
    assign printable  = (char_data >= 7'h20) && (char_data <= 7'h7E);
    assign advance    = ~host_wr_en;
    assign cur_addr   = ADDR_W'(int'(cursor_row) * NUM_COLS + int'(cursor_col));
    assign busy       = rst_n & (state != ST_IDLE);

    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        row_nxt     = cursor_row;
        col_nxt     = cursor_col;
        eng_wr_en   = 1'b0;
        eng_wr_addr = '0;
        eng_wr_data = '0;
        line_feed   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (printable) begin
                        eng_wr_en   = 1'b1;
                        eng_wr_addr = cur_addr;
                        eng_wr_data = char_data;
                        if (cursor_col < LAST_COL) begin
                            col_nxt = cursor_col + 4'd1;
                        end else begin
                            line_feed = 1'b1;
                        end
                    end else if (char_data == CH_LF) begin
                        line_feed = 1'b1;
                    end else if (char_data == CH_CR) begin
                        col_nxt = '0;
                    end else if (char_data == CH_BS) begin
                        if (cursor_col != 4'd0) begin
                            col_nxt = cursor_col - 4'd1;
                        end
                    end
                    // Running off the bottom row keeps the cursor there and shifts the text up.
                    if (line_feed) begin
                        col_nxt = '0;
                        if (cursor_row == LAST_ROW) begin
                            state_nxt = ST_SCROLL_COPY;
                            idx_nxt   = '0;
                        end else begin
                            row_nxt = cursor_row + 2'd1;
                        end
                    end
                end
            end
            ST_SCROLL_COPY: begin
                eng_wr_en   = 1'b1;
                eng_wr_addr = idx;
                eng_wr_data = buf_rd_data;
                if (advance) begin
                    if (idx == COPY_LAST) begin
                        state_nxt = ST_SCROLL_FILL;
                        idx_nxt   = FILL_FIRST;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            ST_SCROLL_FILL, ST_CLEAR: begin
                eng_wr_en   = 1'b1;
                eng_wr_addr = idx;
                eng_wr_data = BLANK_CHAR;
                if (advance) begin
                    if (idx == LAST_CELL) begin
                        state_nxt = ST_IDLE;
                        idx_nxt   = '0;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                idx_nxt   = '0;
            end
        endcase
        // Clear overrides everything, including a scroll in progress or a running clear.
        if (clear) begin
            state_nxt = ST_CLEAR;
            idx_nxt   = '0;
            row_nxt   = '0;
            col_nxt   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            idx        <= '0;
            cursor_row <= '0;
            cursor_col <= '0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            cursor_row <= row_nxt;
            cursor_col <= col_nxt;
        end
    end

    always_comb begin
        buf_wr_en   = 1'b0;
        buf_wr_addr = '0;
        buf_wr_data = '0;
        buf_rd_addr = '0;
        if (rst_n) begin
            if (host_wr_en) begin
                buf_wr_en   = 1'b1;
                buf_wr_addr = host_wr_addr;
                buf_wr_data = host_wr_data;
            end else begin
                buf_wr_en   = eng_wr_en;
                buf_wr_addr = eng_wr_addr;
                buf_wr_data = eng_wr_data;
            end
            if (state == ST_SCROLL_COPY) begin
                buf_rd_addr = idx + COLS_A;
            end
        end
    end

endmodule

// File: tb/tb_vga_console_writer.sv
// Bench for vga_console_writer: behavioural screen model plus a text-buffer RAM,
// engine writes scored against an expected queue and final buffer image.
module tb_vga_console_writer;

    localparam int         COLS  = 10;
    localparam int         CELLS = 30;
    localparam logic [6:0] BLANK = 7'h20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       char_valid;
    logic [6:0] char_data;
    logic       char_ready;
    logic       clear;
    logic       host_wr_en;
    logic [4:0] host_wr_addr;
    logic [6:0] host_wr_data;
    logic       buf_wr_en;
    logic [4:0] buf_wr_addr;
    logic [6:0] buf_wr_data;
    logic [4:0] buf_rd_addr;
    logic [6:0] buf_rd_data;
    logic [1:0] cursor_row;
    logic [3:0] cursor_col;
    logic       busy;

    vga_console_writer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .char_valid   (char_valid),
        .char_data    (char_data),
        .char_ready   (char_ready),
        .clear        (clear),
        .host_wr_en   (host_wr_en),
        .host_wr_addr (host_wr_addr),
        .host_wr_data (host_wr_data),
        .buf_wr_en    (buf_wr_en),
        .buf_wr_addr  (buf_wr_addr),
        .buf_wr_data  (buf_wr_data),
        .buf_rd_addr  (buf_rd_addr),
        .buf_rd_data  (buf_rd_data),
        .cursor_row   (cursor_row),
        .cursor_col   (cursor_col),
        .busy         (busy)
    );

    // Clock and text-buffer RAM with combinational read.
    always #5 clk = ~clk;

    logic [6:0] mem [0:31];
    assign buf_rd_data = mem[buf_rd_addr];
    always @(posedge clk) begin
        if (buf_wr_en === 1'b1) mem[buf_wr_addr] <= buf_wr_data;
    end

    int checks   = 0;
    int failures = 0;
    int pass_bad = 0;

    logic [11:0] exp_q[$];
    logic [12:0] ev_q[$];
    logic [6:0]  mdl_scr [0:31];
    logic [6:0]  ref_mem [0:31];
    int          m_row;
    int          m_col;

    logic       s_busy, s_ready, s_wr_en;
    logic [4:0] s_wr_addr, s_rd_addr;
    logic [6:0] s_wr_data;

    // One clock cycle: entered at a falling edge with inputs already driven.
    task automatic step(output bit acc);
        #2;
        s_busy    = busy;
        s_ready   = char_ready;
        s_wr_en   = buf_wr_en;
        s_wr_addr = buf_wr_addr;
        s_wr_data = buf_wr_data;
        s_rd_addr = buf_rd_addr;
        acc = char_valid && char_ready;
        if (rst_n && host_wr_en) begin
            ev_q.push_back({1'b1, host_wr_addr, host_wr_data});
            if (buf_wr_en !== 1'b1 || buf_wr_addr !== host_wr_addr || buf_wr_data !== host_wr_data)
                pass_bad++;
        end else if (buf_wr_en === 1'b1) begin
            ev_q.push_back({1'b0, buf_wr_addr, buf_wr_data});
        end
        @(negedge clk);
    endtask

    // Reference model: applies one accepted character to the screen model.
    task automatic model_char(input logic [6:0] c);
        bit do_scroll;
        int a;
        do_scroll = 0;
        if (c >= 7'h20 && c <= 7'h7E) begin
            a = m_row * COLS + m_col;
            exp_q.push_back({5'(a), c});
            mdl_scr[a] = c;
            if (m_col < COLS - 1) m_col++;
            else begin
                m_col = 0;
                if (m_row == 2) do_scroll = 1; else m_row++;
            end
        end else if (c == 7'h0A) begin
            m_col = 0;
            if (m_row == 2) do_scroll = 1; else m_row++;
        end else if (c == 7'h0D) begin
            m_col = 0;
        end else if (c == 7'h08) begin
            if (m_col > 0) m_col--;
        end
        if (do_scroll) begin
            for (int i = 0; i < 2 * COLS; i++) begin
                mdl_scr[i] = mdl_scr[i + COLS];
                exp_q.push_back({5'(i), mdl_scr[i]});
            end
            for (int i = 2 * COLS; i < CELLS; i++) begin
                mdl_scr[i] = BLANK;
                exp_q.push_back({5'(i), BLANK});
            end
        end
    endtask

    task automatic send_char(input logic [6:0] c);
        bit acc;
        int n;
        acc = 0;
        n = 0;
        char_valid = 1'b1;
        char_data  = c;
        while (!acc && n < 200) begin
            step(acc);
            n++;
        end
        char_valid = 1'b0;
        checks++;
        if (!acc) begin
            failures++;
            $display("FAIL send_char_timeout char=%h accepted=0 required=1", c);
        end else begin
            model_char(c);
        end
    endtask

    task automatic host_write(input logic [4:0] a, input logic [6:0] d);
        bit acc;
        host_wr_en   = 1'b1;
        host_wr_addr = a;
        host_wr_data = d;
        step(acc);
        host_wr_en   = 1'b0;
        mdl_scr[a]   = d;
    endtask

    task automatic wait_idle(output int n);
        bit acc;
        n = 0;
        step(acc);
        while (s_busy && n < 500) begin
            n++;
            step(acc);
        end
    endtask

    // Scoreboard: replay observed writes in order, score engine writes, compare RAM image.
    task automatic drain_scoreboard(input string tag);
        logic [12:0] ev;
        logic [11:0] ex;
        while (ev_q.size() > 0) begin
            ev = ev_q.pop_front();
            if (ev[12]) begin
                ref_mem[ev[11:7]] = ev[6:0];
            end else begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL %s_extra_write addr=%0d data=%h required=none", tag, ev[11:7], ev[6:0]);
                end else begin
                    ex = exp_q.pop_front();
                    if (ev[11:0] !== ex) begin
                        failures++;
                        $display("FAIL %s_write addr=%0d data=%h required addr=%0d data=%h",
                                 tag, ev[11:7], ev[6:0], ex[11:7], ex[6:0]);
                    end
                    ref_mem[ex[11:7]] = ex[6:0];
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_missing_writes count=%0d required=0", tag, exp_q.size());
        end
        exp_q.delete();
        for (int a = 0; a < CELLS; a++) begin
            checks++;
            if (mem[a] !== ref_mem[a]) begin
                failures++;
                $display("FAIL %s_cell addr=%0d got=%h required=%h", tag, a, mem[a], ref_mem[a]);
            end
            mdl_scr[a] = ref_mem[a];
        end
        checks++;
        if (cursor_row !== 2'(m_row) || cursor_col !== 4'(m_col)) begin
            failures++;
            $display("FAIL %s_cursor got=(%0d,%0d) required=(%0d,%0d)", tag, cursor_row, cursor_col, m_row, m_col);
        end
    endtask

    task automatic test_reset();
        bit acc;
        rst_n = 1'b0;
        host_wr_en = 1'b1;
        host_wr_addr = 5'd7;
        host_wr_data = 7'h55;
        char_valid = 1'b1;
        char_data = 7'h41;
        step(acc);
        checks++;
        if (s_wr_en !== 1'b0 || s_wr_addr !== 5'd0 || s_wr_data !== 7'd0 || s_rd_addr !== 5'd0) begin
            failures++;
            $display("FAIL reset_port got en=%b addr=%0d data=%h rd=%0d required 0/0/0/0",
                     s_wr_en, s_wr_addr, s_wr_data, s_rd_addr);
        end
        checks++;
        if (s_ready !== 1'b0 || s_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags got ready=%b busy=%b required 0/0", s_ready, s_busy);
        end
        host_wr_en = 1'b0;
        char_valid = 1'b0;
        step(acc);
        rst_n = 1'b1;
        step(acc);
        checks++;
        if (s_ready !== 1'b1 || s_busy !== 1'b0 || cursor_row !== 2'd0 || cursor_col !== 4'd0) begin
            failures++;
            $display("FAIL reset_release got ready=%b busy=%b cursor=(%0d,%0d) required 1/0/(0,0)",
                     s_ready, s_busy, cursor_row, cursor_col);
        end
        m_row = 0;
        m_col = 0;
    endtask

    task automatic test_clear_initial();
        bit acc;
        int n;
        ev_q.delete();
        clear = 1'b1;
        step(acc);
        clear = 1'b0;
        for (int i = 0; i < CELLS; i++) begin
            mdl_scr[i] = BLANK;
            exp_q.push_back({5'(i), BLANK});
        end
        m_row = 0;
        m_col = 0;
        wait_idle(n);
        checks++;
        if (n != 30) begin
            failures++;
            $display("FAIL clear_busy_cycles got=%0d required=30", n);
        end
        drain_scoreboard("clear_init");
    endtask

    task automatic test_ab();
        bit acc;
        send_char(7'h41);
        checks++;
        if (s_wr_en !== 1'b1 || s_wr_addr !== 5'd0 || s_wr_data !== 7'h41 || s_busy !== 1'b0) begin
            failures++;
            $display("FAIL ab_first got en=%b addr=%0d data=%h busy=%b required 1/0/41/0",
                     s_wr_en, s_wr_addr, s_wr_data, s_busy);
        end
        send_char(7'h42);
        checks++;
        if (s_wr_en !== 1'b1 || s_wr_addr !== 5'd1 || s_wr_data !== 7'h42 || s_busy !== 1'b0) begin
            failures++;
            $display("FAIL ab_second got en=%b addr=%0d data=%h busy=%b required 1/1/42/0",
                     s_wr_en, s_wr_addr, s_wr_data, s_busy);
        end
        step(acc);
        checks++;
        if (s_busy !== 1'b0 || cursor_row !== 2'd0 || cursor_col !== 4'd2) begin
            failures++;
            $display("FAIL ab_cursor got busy=%b cursor=(%0d,%0d) required 0/(0,2)", s_busy, cursor_row, cursor_col);
        end
        drain_scoreboard("ab");
    endtask

    task automatic test_wrap_controls();
        send_char(7'h0D);
        for (int i = 0; i < 10; i++) send_char(7'h61);
        checks++;
        if (cursor_row !== 2'd1 || cursor_col !== 4'd0) begin
            failures++;
            $display("FAIL wrap_cursor got=(%0d,%0d) required=(1,0)", cursor_row, cursor_col);
        end
        for (int i = 0; i < 3; i++) send_char(7'h62);
        send_char(7'h0D);
        checks++;
        if (cursor_row !== 2'd1 || cursor_col !== 4'd0) begin
            failures++;
            $display("FAIL cr_cursor got=(%0d,%0d) required=(1,0)", cursor_row, cursor_col);
        end
        send_char(7'h08);
        checks++;
        if (cursor_row !== 2'd1 || cursor_col !== 4'd0) begin
            failures++;
            $display("FAIL bs_col0_cursor got=(%0d,%0d) required=(1,0)", cursor_row, cursor_col);
        end
        for (int i = 0; i < 4; i++) send_char(7'h63);
        send_char(7'h08);
        checks++;
        if (cursor_row !== 2'd1 || cursor_col !== 4'd3) begin
            failures++;
            $display("FAIL bs_col4_cursor got=(%0d,%0d) required=(1,3)", cursor_row, cursor_col);
        end
        drain_scoreboard("wrap");
    endtask

    task automatic test_scroll();
        int n;
        send_char(7'h0D);
        while (m_row < 2) send_char(7'h0A);
        for (int i = 0; i < 9; i++) send_char(7'h79);
        for (int i = 0; i < 10; i++) host_write(5'(10 + i), 7'h78);
        send_char(7'h7A);
        checks++;
        if (s_wr_addr !== 5'd29 || s_wr_data !== 7'h7A) begin
            failures++;
            $display("FAIL scroll_z_write got addr=%0d data=%h required 29/7a", s_wr_addr, s_wr_data);
        end
        wait_idle(n);
        checks++;
        if (n != 30) begin
            failures++;
            $display("FAIL scroll_busy_cycles got=%0d required=30", n);
        end
        for (int a = 0; a < CELLS; a++) begin
            logic [6:0] want;
            want = (a < 10) ? 7'h78 : (a < 19) ? 7'h79 : (a == 19) ? 7'h7A : BLANK;
            checks++;
            if (mem[a] !== want) begin
                failures++;
                $display("FAIL scroll_image addr=%0d got=%h required=%h", a, mem[a], want);
            end
        end
        drain_scoreboard("scroll");
    endtask

    task automatic test_scroll_host_stall();
        bit acc;
        int n, stalls, k;
        for (int i = 0; i < 10; i++) send_char(7'($urandom_range(32, 126)));
        pass_bad = 0;
        n = 0;
        stalls = 0;
        k = 0;
        do begin
            host_wr_en   = (k % 2 == 0);
            host_wr_addr = 5'($urandom_range(0, 9));
            host_wr_data = 7'($urandom_range(0, 127));
            step(acc);
            if (s_busy) begin
                n++;
                if (host_wr_en) stalls++;
            end
            k++;
        end while (s_busy && k < 400);
        host_wr_en = 1'b0;
        checks++;
        if (n != 60 || stalls != 30) begin
            failures++;
            $display("FAIL stall_busy_cycles got busy=%0d stalls=%0d required 60/30", n, stalls);
        end
        checks++;
        if (pass_bad != 0) begin
            failures++;
            $display("FAIL host_passthrough bad_cycles=%0d required=0", pass_bad);
        end
        drain_scoreboard("stall");
    endtask

    task automatic test_random_stream();
        int n;
        int r;
        logic [6:0] c;
        pass_bad = 0;
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 11);
            if (r <= 5) c = 7'($urandom_range(32, 126));
            else if (r == 6) c = 7'h0A;
            else if (r == 7) c = 7'h0D;
            else if (r == 8) c = 7'h08;
            else if (r == 9) c = ($urandom_range(0, 1) == 0) ? 7'h7F : 7'($urandom_range(0, 7));
            else c = 7'h20;
            send_char(c);
            if (r == 11) begin
                wait_idle(n);
                host_write(5'($urandom_range(0, 29)), 7'($urandom_range(0, 127)));
            end
        end
        wait_idle(n);
        checks++;
        if (pass_bad != 0) begin
            failures++;
            $display("FAIL random_host_passthrough bad_cycles=%0d required=0", pass_bad);
        end
        drain_scoreboard("random");
    endtask

    task automatic test_clear_mid_scroll();
        bit acc;
        int n, early;
        send_char(7'h0D);
        while (m_row < 2) send_char(7'h0A);
        send_char(7'h0A);
        early = 0;
        for (int i = 0; i < 9; i++) begin
            step(acc);
            if (s_busy) early++;
        end
        clear = 1'b1;
        step(acc);
        if (s_busy) early++;
        clear = 1'b0;
        checks++;
        if (early != 10) begin
            failures++;
            $display("FAIL clear_mid_scroll_pre got busy=%0d required=10", early);
        end
        wait_idle(n);
        checks++;
        if (n != 30) begin
            failures++;
            $display("FAIL clear_mid_scroll_busy got=%0d required=30", n);
        end
        for (int a = 0; a < CELLS; a++) begin
            checks++;
            if (mem[a] !== BLANK) begin
                failures++;
                $display("FAIL clear_mid_scroll_cell addr=%0d got=%h required=20", a, mem[a]);
            end
            ref_mem[a] = BLANK;
            mdl_scr[a] = BLANK;
        end
        checks++;
        if (cursor_row !== 2'd0 || cursor_col !== 4'd0) begin
            failures++;
            $display("FAIL clear_mid_scroll_cursor got=(%0d,%0d) required=(0,0)", cursor_row, cursor_col);
        end
        ev_q.delete();
        exp_q.delete();
        m_row = 0;
        m_col = 0;
    endtask

    task automatic test_reset_mid_clear();
        bit acc;
        send_char(7'h51);
        clear = 1'b1;
        step(acc);
        clear = 1'b0;
        for (int i = 0; i < 4; i++) step(acc);
        rst_n = 1'b0;
        step(acc);
        checks++;
        if (s_wr_en !== 1'b0 || s_busy !== 1'b0 || s_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_clear_low got en=%b busy=%b ready=%b required 0/0/0", s_wr_en, s_busy, s_ready);
        end
        rst_n = 1'b1;
        ev_q.delete();
        step(acc);
        checks++;
        if (s_busy !== 1'b0 || s_ready !== 1'b1 || cursor_row !== 2'd0 || cursor_col !== 4'd0) begin
            failures++;
            $display("FAIL reset_mid_clear_after got busy=%b ready=%b cursor=(%0d,%0d) required 0/1/(0,0)",
                     s_busy, s_ready, cursor_row, cursor_col);
        end
        for (int i = 0; i < 10; i++) step(acc);
        checks++;
        if (ev_q.size() != 0) begin
            failures++;
            $display("FAIL reset_mid_clear_writes got=%0d required=0", ev_q.size());
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        char_valid   = 1'b0;
        char_data    = '0;
        clear        = 1'b0;
        host_wr_en   = 1'b0;
        host_wr_addr = '0;
        host_wr_data = '0;
        for (int a = 0; a < 32; a++) begin
            mdl_scr[a] = BLANK;
            ref_mem[a] = BLANK;
        end
        m_row = 0;
        m_col = 0;
        @(negedge clk);
        test_reset();
        test_clear_initial();
        test_ab();
        test_wrap_controls();
        test_scroll();
        test_scroll_host_stall();
        test_random_stream();
        test_clear_mid_scroll();
        test_reset_mid_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_console_writer.md
Name: vga_console_writer

Overview:
- Terminal-style write controller for the 3x10 character text buffer of the VGA console peripheral.
- Accepts a stream of 7-bit characters and keeps a cursor. It handles CR, LF and BS control codes, auto-wraps at the end of a line, and scrolls the buffer up one row when output runs past the last row.
- It owns the single buffer write port and arbitrates it against direct host register writes.
- Host writes always win the port.

Parameters:
- NUM_ROWS, 3: text rows.
- NUM_COLS, 10: text columns.
- ADDR_W, 5: buffer address width. Must satisfy 2^ADDR_W >= NUM_ROWS*NUM_COLS.
- BLANK_CHAR, 7'h20: fill value used for clear and scroll.

Ports:
- clk  in  1  project clock (64 MHz).
- rst_n  in  1  reset, synchronous, active-low.
- char_valid  in  1  stream character valid.
- char_data  in  7  stream character.
- char_ready  out  1  stream character accepted this cycle when high together with char_valid.
- clear  in  1  single-cycle pulse: blank the whole screen and home the cursor.
- host_wr_en  in  1  direct host write to the buffer.
- host_wr_addr  in  ADDR_W  host write address.
- host_wr_data  in  7  host write data.
- buf_wr_en  out  1  text buffer write enable.
- buf_wr_addr  out  ADDR_W  text buffer write address.
- buf_wr_data  out  7  text buffer write data.
- buf_rd_addr  out  ADDR_W  text buffer read address. The buffer returns data combinationally.
- buf_rd_data  in  7  text buffer read data.
- cursor_row  out  2  current cursor row.
- cursor_col  out  4  current cursor column.
- busy  out  1  high when state != IDLE.

Behaviour:
- One clock domain: clk. Reset is synchronous, active-low on rst_n.
- While rst_n is low:
  - State becomes IDLE, cursor becomes (0,0), index becomes 0.
  - char_ready = 0, busy = 0, buf_wr_en = 0, buf_wr_addr = 0, buf_wr_data = 0, buf_rd_addr = 0.
- Reset asserted mid-scroll or mid-clear abandons the operation; buffer contents are left as-is.
- Cursor address = row*NUM_COLS + col.
- States:
  - IDLE: accepts stream characters.
  - SCROLL_COPY, SCROLL_FILL, CLEAR: engine states.
- Write-port mux (combinational):
  - host_wr_en = 1: the host write passes through unchanged. Any engine or stream write is suppressed that cycle and retried.
  - Otherwise the engine or stream write is driven.
- char_ready = rst_n & (state==IDLE) & ~host_wr_en & ~clear. It is combinational; there is no skid buffer.
- Accept cycle (char_valid & char_ready) by character class:
  - Printable 0x20..0x7E: buf_wr_en=1, addr=cursor address, data=char, in the same cycle. Then, at the next edge:
    - col < NUM_COLS-1: col+1.
    - Otherwise col=0 and row+1.
    - If row was NUM_ROWS-1: row stays, go to SCROLL_COPY.
  - 0x0A (LF): col=0 and row+1, or scroll if on the last row. No write.
  - 0x0D (CR): col=0. No write.
  - 0x08 (BS): if col>0, col-1. No erase, no reverse wrap.
  - Any other code: consumed and ignored.
- SCROLL_COPY:
  - Index i runs 0..(NUM_ROWS-1)*NUM_COLS-1.
  - buf_rd_addr = i+NUM_COLS. Write addr = i, data = buf_rd_data.
  - i advances only on cycles with no host write.
  - After the last i: go to SCROLL_FILL with i = (NUM_ROWS-1)*NUM_COLS.
- SCROLL_FILL:
  - Writes BLANK_CHAR at i up to NUM_ROWS*NUM_COLS-1, with the same stall rule, then returns to IDLE.
  - Cursor is already (NUM_ROWS-1, 0).
  - Unstalled scroll takes 30 cycles of busy for the default parameters.
- CLEAR:
  - Entered from any state on clear (this aborts a scroll).
  - i=0, cursor (0,0) at the same edge.
  - Writes BLANK_CHAR to 0..NUM_CHARS-1 with the stall rule, then goes to IDLE. Unstalled this takes 30 cycles.
  - clear while in CLEAR restarts at i=0.
- buf_rd_addr = 0 outside SCROLL_COPY.
- cursor_row and cursor_col are registered. Cursor values outside the buffer are never reachable.

Test Plan:
1. After reset, stream "AB": writes addr0=0x41 and addr1=0x42 in their accept cycles; cursor ends at (0,2); busy=0 throughout.
2. Stream 10 chars 'a' on row 0: the 10th wraps the cursor to (1,0). Then CR at (1,3) gives (1,0). BS at col 0 gives no change. BS at col 4 gives col 3.
3. Preload rows 1 and 2 with 'x' and 'y', cursor (2,9), send 'z': addr29='z', then busy for exactly 30 cycles. Afterwards rows 0 and 1 hold the old rows 1 and 2 (row 1 ends in 'z'), row 2 is all 0x20, and the cursor is (2,0).
4. Host write every other cycle during a scroll: host writes land unmodified; scroll stretches to 30 engine writes (about 60 cycles); the final buffer equals the scroll result overwritten by the later host writes.
5. Assert clear mid-scroll (cycle 10): all 30 cells become 0x20, cursor (0,0), busy drops after 30 cycles.
6. Assert rst_n low for 1 cycle mid-clear: next cycle busy=0, char_ready=1, cursor (0,0), no further engine writes.
